// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped, one-word-per-line instruction cache between an
//               sram-like CPU port and an AXI bridge. Optional read hit/miss
//               counters are enabled by defining ICACHE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_dm #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,

    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok,

    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        REFILL = 2'd3
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_addr;
    logic                   r_wr;
    logic [1:0]             r_size;
    logic [31:0]            r_wdata;
    logic [LINES-1:0]       r_valid;
    logic [TAG_WIDTH-1:0]   r_tag_arr  [LINES];
    logic [31:0]            r_data_arr [LINES];

    logic [INDEX_WIDTH-1:0] w_index;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic                   w_hit;
    logic                   w_read_hit;
    logic                   w_read_miss;
    logic                   w_refill_done;

    // Lookup always uses the captured address, never the live CPU inputs.
    assign w_index       = r_addr[INDEX_WIDTH+1:2];
    assign w_tag         = r_addr[31:INDEX_WIDTH+2];
    assign w_hit         = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);
    assign w_read_hit    = (r_state == LOOKUP) && !r_wr && w_hit;
    assign w_read_miss   = (r_state == LOOKUP) && !r_wr && !w_hit;
    assign w_refill_done = (r_state == REFILL) && cache_inst_data_ok;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_wdata <= '0;
            r_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_inst_req) begin
                        r_addr  <= cpu_inst_addr;
                        r_wr    <= cpu_inst_wr;
                        r_size  <= cpu_inst_size;
                        r_wdata <= cpu_inst_wdata;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_read_hit) begin
                        r_state <= IDLE;
                    end else begin
                        // Writes bypass the cache; drop any stale copy of the word.
                        if (r_wr && w_hit) begin
                            r_valid[w_index] <= 1'b0;
                        end
                        r_state <= MISS;
                    end
                end
                MISS: begin
                    if (cache_inst_addr_ok) begin
                        r_state <= REFILL;
                    end
                end
                REFILL: begin
                    if (cache_inst_data_ok) begin
                        if (!r_wr) begin
                            r_valid[w_index] <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag/data storage needs no reset: the valid bits gate every use.
    always_ff @(posedge aclk) begin
        if (w_refill_done && !r_wr) begin
            r_tag_arr[w_index]  <= w_tag;
            r_data_arr[w_index] <= cache_inst_rdata;
        end
    end

    assign cpu_inst_addr_ok = (r_state == IDLE);
    assign cpu_inst_data_ok = w_read_hit || w_refill_done;
    assign cpu_inst_rdata   = w_refill_done ? cache_inst_rdata :
                              w_read_hit    ? r_data_arr[w_index] : 32'd0;

    assign cache_inst_req   = (r_state == MISS);
    assign cache_inst_wr    = r_wr;
    assign cache_inst_size  = r_size;
    assign cache_inst_addr  = r_addr;
    assign cache_inst_wdata = r_wdata;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_read_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_read_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_dm
// Description : Directed scoreboard bench for icache_dm (default INDEX_WIDTH).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_dm;

`ifdef ICACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        aclk;
    logic        aresetn;
    logic        cpu_inst_req;
    logic        cpu_inst_wr;
    logic [1:0]  cpu_inst_size;
    logic [31:0] cpu_inst_addr;
    logic [31:0] cpu_inst_wdata;
    logic [31:0] cpu_inst_rdata;
    logic        cpu_inst_addr_ok;
    logic        cpu_inst_data_ok;
    logic        cache_inst_req;
    logic        cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr;
    logic [31:0] cache_inst_wdata;
    logic [31:0] cache_inst_rdata;
    logic        cache_inst_addr_ok;
    logic        cache_inst_data_ok;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_dm dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cpu_inst_req       (cpu_inst_req),
        .cpu_inst_wr        (cpu_inst_wr),
        .cpu_inst_size      (cpu_inst_size),
        .cpu_inst_addr      (cpu_inst_addr),
        .cpu_inst_wdata     (cpu_inst_wdata),
        .cpu_inst_rdata     (cpu_inst_rdata),
        .cpu_inst_addr_ok   (cpu_inst_addr_ok),
        .cpu_inst_data_ok   (cpu_inst_data_ok),
        .cache_inst_req     (cache_inst_req),
        .cache_inst_wr      (cache_inst_wr),
        .cache_inst_size    (cache_inst_size),
        .cache_inst_addr    (cache_inst_addr),
        .cache_inst_wdata   (cache_inst_wdata),
        .cache_inst_rdata   (cache_inst_rdata),
        .cache_inst_addr_ok (cache_inst_addr_ok),
        .cache_inst_data_ok (cache_inst_data_ok),
        .hit_cnt            (hit_cnt),
        .miss_cnt           (miss_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          errors = 0;
    int          checks = 0;
    int          br_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_hit = 0;
    logic [31:0] exp_miss = 0;

    // Count bridge request handshakes.
    always @(posedge aclk) begin
        if (cache_inst_req && cache_inst_addr_ok) br_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=data_ok expected=empty scoreboard", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, cpu_inst_rdata, e);
        end
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_hit_cnt"},  hit_cnt,  PERF ? exp_hit  : 32'd0);
        check({tag, "_miss_cnt"}, miss_cnt, PERF ? exp_miss : 32'd0);
    endtask

    // One CPU transaction. data is the bridge return on a miss and the
    // expected cached word on a hit. abort leaves the DUT sitting in REFILL.
    task automatic do_req(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit miss,
                          input logic [31:0] data, input int stall, input bit abort);
        int br0;
        br0 = br_cnt;
        @(negedge aclk);
        cpu_inst_req   = 1'b1;
        cpu_inst_wr    = wr;
        cpu_inst_size  = 2'd2;
        cpu_inst_addr  = addr;
        cpu_inst_wdata = wdata;
        exp_q.push_back(data);
        #1 check({tag, "_addr_ok"}, {31'd0, cpu_inst_addr_ok}, 32'd1);
        @(posedge aclk);
        @(negedge aclk);
        cpu_inst_req  = 1'b0;
        cpu_inst_addr = 32'hFFFF_FFFC;
        if (!wr) begin
            if (miss) exp_miss++;
            else      exp_hit++;
        end
        #1;
        if (!miss) begin
            check({tag, "_hit_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd1);
            check_data(tag);
            @(posedge aclk);
        end else begin
            check({tag, "_lookup_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd0);
            @(posedge aclk);
            @(negedge aclk);
            cache_inst_data_ok = 1'b1;
            cache_inst_rdata   = 32'hBAD0_BAD0;
            #1;
            check({tag, "_miss_req"},   {31'd0, cache_inst_req}, 32'd1);
            check({tag, "_miss_addr"},  cache_inst_addr, addr);
            check({tag, "_miss_wr"},    {31'd0, cache_inst_wr}, {31'd0, wr});
            check({tag, "_miss_size"},  {30'd0, cache_inst_size}, 32'd2);
            check({tag, "_miss_ok"},    {31'd0, cpu_inst_data_ok}, 32'd0);
            check({tag, "_miss_rdata"}, cpu_inst_rdata, 32'd0);
            if (wr) check({tag, "_miss_wdata"}, cache_inst_wdata, wdata);
            cache_inst_data_ok = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(posedge aclk);
                @(negedge aclk);
                #1;
                check({tag, "_stall_req"},     {31'd0, cache_inst_req}, 32'd1);
                check({tag, "_stall_addr"},    cache_inst_addr, addr);
                check({tag, "_stall_addr_ok"}, {31'd0, cpu_inst_addr_ok}, 32'd0);
            end
            cache_inst_addr_ok = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            cache_inst_addr_ok = 1'b0;
            #1;
            check({tag, "_refill_req"}, {31'd0, cache_inst_req}, 32'd0);
            check({tag, "_refill_ok"},  {31'd0, cpu_inst_data_ok}, 32'd0);
            check({tag, "_bridge_reqs"}, br_cnt - br0, 32'd1);
            if (abort) return;
            cache_inst_rdata   = data;
            cache_inst_data_ok = 1'b1;
            #1;
            check({tag, "_refill_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd1);
            check_data(tag);
            @(posedge aclk);
        end
        @(negedge aclk);
        cache_inst_data_ok = 1'b0;
        cache_inst_rdata   = 32'hA5A5_A5A5;
        #1;
        check({tag, "_idle_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd0);
        check({tag, "_idle_rdata"},   cpu_inst_rdata, 32'd0);
        check({tag, "_idle_addr_ok"}, {31'd0, cpu_inst_addr_ok}, 32'd1);
        if (!miss) check({tag, "_bridge_reqs"}, br_cnt - br0, 32'd0);
        check_cnt(tag);
    endtask

    initial begin
        aresetn            = 1'b0;
        cpu_inst_req       = 1'b0;
        cpu_inst_wr        = 1'b0;
        cpu_inst_size      = 2'd2;
        cpu_inst_addr      = 32'd0;
        cpu_inst_wdata     = 32'd0;
        cache_inst_rdata   = 32'd0;
        cache_inst_addr_ok = 1'b0;
        cache_inst_data_ok = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check("rst_addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd1);
        check("rst_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
        check("rst_rdata",   cpu_inst_rdata, 32'd0);
        check("rst_req",     {31'd0, cache_inst_req}, 32'd0);
        check("rst_addr",    cache_inst_addr, 32'd0);
        check_cnt("rst");
        @(negedge aclk);
        aresetn = 1'b1;

        do_req("cold",     1'b0, 32'h1FC0_0000, 32'd0, 1'b1, 32'h3C04_8000, 0, 1'b0);
        do_req("hit",      1'b0, 32'h1FC0_0000, 32'd0, 1'b0, 32'h3C04_8000, 0, 1'b0);
        do_req("conflict", 1'b0, 32'h1FC0_1000, 32'd0, 1'b1, 32'h1111_2222, 0, 1'b0);
        do_req("conf_hit", 1'b0, 32'h1FC0_1000, 32'd0, 1'b0, 32'h1111_2222, 0, 1'b0);
        do_req("evicted",  1'b0, 32'h1FC0_0000, 32'd0, 1'b1, 32'h3C04_8000, 5, 1'b0);
        do_req("idx1",     1'b0, 32'h1FC0_0004, 32'd0, 1'b1, 32'h2400_0001, 0, 1'b0);
        do_req("idx0_hit", 1'b0, 32'h1FC0_0000, 32'd0, 1'b0, 32'h3C04_8000, 0, 1'b0);
        do_req("write",    1'b1, 32'h1FC0_0000, 32'd0, 1'b1, 32'hDEAD_0001, 0, 1'b0);
        do_req("post_wr",  1'b0, 32'h1FC0_0000, 32'd0, 1'b1, 32'h3C04_8001, 0, 1'b0);
        do_req("post_hit", 1'b0, 32'h1FC0_0000, 32'd0, 1'b0, 32'h3C04_8001, 0, 1'b0);

        // Reset while REFILL is waiting on the bridge.
        do_req("abort",    1'b0, 32'h0000_0100, 32'd0, 1'b1, 32'h7777_7777, 0, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        exp_q.delete();
        exp_hit  = 0;
        exp_miss = 0;
        check("arst_addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd1);
        check("arst_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
        check("arst_req",     {31'd0, cache_inst_req}, 32'd0);
        check_cnt("arst");
        @(negedge aclk);
        aresetn = 1'b1;
        #1 check("rel_addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd1);

        do_req("inv_idx1", 1'b0, 32'h1FC0_0004, 32'd0, 1'b1, 32'h2400_0002, 0, 1'b0);
        do_req("inv_idx0", 1'b0, 32'h1FC0_0000, 32'd0, 1'b1, 32'h3C04_8002, 0, 1'b0);
        do_req("abort_ln", 1'b0, 32'h0000_0100, 32'd0, 1'b1, 32'h0BAD_F00D, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6, the line-index width (2^INDEX_WIDTH one-word lines).
REQ-002 SHALL have port aclk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_inst_req  input  1  request from the sram-like converter.
REQ-005 SHALL have port cpu_inst_wr  input  1  1=write, 0=read.
REQ-006 SHALL have port cpu_inst_size  input  2  transfer size, 2=word.
REQ-007 SHALL have port cpu_inst_addr  input  32  physical address.
REQ-008 SHALL have port cpu_inst_wdata  input  32  write data.
REQ-009 SHALL have port cpu_inst_rdata  output  32  read data, valid with cpu_inst_data_ok.
REQ-010 SHALL have port cpu_inst_addr_ok  output  1  request accepted.
REQ-011 SHALL have port cpu_inst_data_ok  output  1  transaction complete.
REQ-012 SHALL have port cache_inst_req  output  1  request to the AXI bridge.
REQ-013 SHALL have port cache_inst_wr  output  1  forwarded write flag.
REQ-014 SHALL have port cache_inst_size  output  2  forwarded size.
REQ-015 SHALL have port cache_inst_addr  output  32  forwarded address.
REQ-016 SHALL have port cache_inst_wdata  output  32  forwarded write data.
REQ-017 SHALL have port cache_inst_rdata  input  32  bridge read data.
REQ-018 SHALL have port cache_inst_addr_ok  input  1  bridge accepted request.
REQ-019 SHALL have port cache_inst_data_ok  input  1  bridge completed transaction.
REQ-020 SHALL have port hit_cnt  output  32  read-hit counter.
REQ-021 SHALL have port miss_cnt  output  32  read-miss counter.

Function
REQ-022 SHALL split address: index = addr[INDEX_WIDTH+1:2], tag = addr[31:INDEX_WIDTH+2]; each line holds valid, tag, 32-bit word.
REQ-023 SHALL implement FSM IDLE, LOOKUP, MISS, REFILL; cpu_inst_addr_ok = 1 only in IDLE.
REQ-024 SHALL, in IDLE on cpu_inst_req=1, register addr/wr/size/wdata and go to LOOKUP next cycle.
REQ-025 SHALL, in LOOKUP on read with valid and tag match (hit), assert cpu_inst_data_ok for one cycle with the stored word and return to IDLE (data_ok exactly 1 cycle after the handshake).
REQ-026 SHALL, in LOOKUP on read miss or any write, go to MISS; a write that hits SHALL clear that line's valid bit.
REQ-027 SHALL, in MISS, hold cache_inst_req=1 with registered addr/wr/size/wdata until cache_inst_addr_ok=1, then go to REFILL; cache_inst_req SHALL be 0 in all other states.
REQ-028 SHALL, in REFILL on cache_inst_data_ok=1, pass cache_inst_rdata to cpu_inst_rdata, assert cpu_inst_data_ok that same cycle, and return to IDLE; for reads it SHALL write valid=1, tag, data into the line, for writes the array is unchanged.
REQ-029 SHALL ignore cache_inst_data_ok outside REFILL and cpu_inst_req outside IDLE.
REQ-030 SHALL keep cpu_inst_data_ok 0 in IDLE and MISS; cpu_inst_rdata SHALL be 0 when cpu_inst_data_ok=0.

Reset
REQ-031 SHALL, on aresetn=0, asynchronously enter IDLE, clear every valid bit, and clear both counters and all outputs driven from registers to 0.
REQ-032 SHALL, on reset during MISS/REFILL, abandon the transaction with no line written; the AXI bridge is reset by the same signal.

Configuration
REQ-033 SHALL, with ICACHE_PERF_CNT_EN defined, increment hit_cnt on each read hit and miss_cnt on each read miss (LOOKUP cycle), wrapping at 2^32.
REQ-034 SHALL, without ICACHE_PERF_CNT_EN, tie hit_cnt and miss_cnt to 0 with no counter registers.

Verification
REQ-035 SHALL cover cold read 0x1FC00000 -> one cache_inst_req at 0x1FC00000; bridge returns 0x3C048000; cpu_inst_data_ok with 0x3C048000; miss_cnt=1.
REQ-036 SHALL cover repeat read 0x1FC00000 -> no cache_inst_req, data_ok 1 cycle after handshake with 0x3C048000; hit_cnt=1.
REQ-037 SHALL cover conflicting read 0x1FC01000 (same index, INDEX_WIDTH=6 -> tag differs) -> refill replaces line; subsequent 0x1FC00000 misses again.
REQ-038 SHALL cover write 0x1FC00000 wdata 0x0 on a valid line -> forwarded with wr=1, line invalidated; next read misses.
REQ-039 SHALL cover aresetn pulled low during REFILL -> IDLE, addr_ok=1 after release, all lines invalid, counters 0.
REQ-040 SHALL cover bridge holding cache_inst_addr_ok=0 for 5 cycles -> cache_inst_req and cache_inst_addr stable, cpu_inst_addr_ok=0 throughout.
